switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Upstream input-conditioning stage for the switch bank that drives the gate-select logic.
- Takes the raw, asynchronous, bouncing slide-switch inputs, synchronises them into the clk domain and debounces each bit independently.
- Presents a clean, stable switch bus to the downstream combinational gate/mux stage.
- Also provides a one-cycle change strobe and a per-bit change mask so later sequential logic can react to switch edits.

Parameters:
- WIDTH, 5, number of switch bits conditioned (bits [1:0] are gate operands, [4:2] are the gate select).
- CNT_MAX, 1000000, consecutive clk cycles a synchronised bit must differ from its output before the output flips (10 ms at 100 MHz); legal range >= 1.
- CNT_W, clog2(CNT_MAX) with a minimum of 1, width of each per-bit stability counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  WIDTH  raw switch pins; asynchronous to clk, may bounce.
- sw_out  output  WIDTH  debounced, synchronised switch value; feeds the gate/mux stage SW bus.
- changed  output  1  single-cycle pulse, high in the cycle after any sw_out bit updates.
- change_mask  output  WIDTH  bits of sw_out that flipped on the same edge that raised changed; all 0 otherwise.

Behaviour:
- Reset (rst high at a rising edge):
  - Clears both synchroniser stages, all counters, sw_out, changed and change_mask to 0.
  - Applies regardless of in-flight debounce state.
  - Reset mid-debounce discards the partial count; outputs stay 0 while rst is high.
- Synchroniser:
  - Per bit, two flops in series: sync1 <= sw_raw, then sync2 <= sync1.
  - No logic between the stages.
  - Only sync2 is used downstream.
- Per-bit debounce, evaluated every rising edge with rst low:
  - sync2[i] == sw_out[i]: cnt[i] <= 0.
  - sync2[i] != sw_out[i] and cnt[i] < CNT_MAX-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != sw_out[i] and cnt[i] == CNT_MAX-1: sw_out[i] <= sync2[i], cnt[i] <= 0, change_mask[i] <= 1.
  - Any single cycle of agreement (a bounce back) restarts the count from 0.
  - cnt never exceeds CNT_MAX-1; there is no wrap.
- Latency:
  - A clean raw transition sampled at edge E0 appears on sw_out after edge E0+1+CNT_MAX, i.e. CNT_MAX+2 edges total.
  - For CNT_MAX=1 this is 3 edges.
- Strobes:
  - change_mask is registered; bits not flipping on a given edge are 0.
  - changed is registered as the OR of the next-state change_mask, so it is high exactly in the cycles where change_mask is nonzero.
  - Both are single-cycle pulses, never held.
- Independence and simultaneous events:
  - Bits are fully independent.
  - Several bits completing on the same edge produce one changed pulse with multiple change_mask bits set.
  - Bits completing on consecutive edges produce back-to-back pulses.
- Steady state: sw_out holds indefinitely while sync2 == sw_out; no spurious strobes.
- After reset with switches already high: each high bit propagates to sw_out CNT_MAX+2 edges after rst deasserts, with a changed pulse.
- Purely synchronous design; no latches, no combinational path from sw_raw to any output.

Test Plan:
- Reset release: CNT_MAX=4, sw_raw=5'b00000, rst high 3 cycles then low. Required: sw_out=0, changed=0 and change_mask=0 throughout and for 20 cycles after.
- Clean single-bit change: CNT_MAX=4, after reset set sw_raw=5'b00001 at edge E0. Required: sw_out=5'b00001 after edge E0+5 (not before), changed=1 and change_mask=5'b00001 for exactly that one cycle, then both 0.
- Bounce rejection: CNT_MAX=4, toggle sw_raw[2] as 1,0,1,0,1 on successive cycles, then hold 1. Required: no sw_out change until 6 edges after the final rising toggle; exactly one changed pulse; sw_out=5'b00100.
- Simultaneous bits: CNT_MAX=4, from 0 set sw_raw=5'b10011 in one cycle. Required: all three bits update on the same edge, one changed pulse, change_mask=5'b10011.
- Reset mid-debounce: CNT_MAX=8, set sw_raw=5'b11111, assert rst for 1 cycle after 5 edges. Required: sw_out stays 0 through reset; sw_out=5'b11111 exactly 10 edges after the first edge with rst low; one changed pulse.
- Falling edge and minimum parameter: CNT_MAX=1, with sw_out=5'b01000 set sw_raw=0. Required: sw_out=0 after 3 edges, change_mask=5'b01000 for one cycle.

Source files
------------

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Brief    : Two-flop synchroniser plus independent per-bit debounce counters
//            with a registered change strobe and change mask.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int WIDTH   = 5,
    parameter int CNT_MAX = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic             changed,
    output logic [WIDTH-1:0] change_mask
);

    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CNT_MAX - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sw_out;
    logic [WIDTH-1:0] r_mask;
    logic             r_changed;
    logic [WIDTH-1:0] w_flip;

    // Each bit owns a stability counter; it flips its output on the
    // CNT_MAX-th consecutive cycle of disagreement.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;
        logic             w_differs;

        assign w_differs = r_sync2[i] ^ r_sw_out[i];
        assign w_flip[i] = w_differs && (r_cnt == c_cnt_last);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (!w_differs || w_flip[i]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sw_out  <= '0;
            r_mask    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_sync1   <= sw_raw;
            r_sync2   <= r_sync1;
            r_sw_out  <= r_sw_out ^ w_flip;
            r_mask    <= w_flip;
            r_changed <= |w_flip;
        end
    end

    assign sw_out      = r_sw_out;
    assign changed     = r_changed;
    assign change_mask = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debouncer
// Brief    : Self-checking bench for switch_debouncer at CNT_MAX = 4, 8 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic [4:0] raw_a = '0, raw_b = '0, raw_c = '0;
    logic [4:0] out_a, out_b, out_c;
    logic [4:0] mask_a, mask_b, mask_c;
    logic       chg_a, chg_b, chg_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    switch_debouncer #(.WIDTH(5), .CNT_MAX(4)) dut_a (
        .clk(clk), .rst(rst_a), .sw_raw(raw_a),
        .sw_out(out_a), .changed(chg_a), .change_mask(mask_a)
    );
    switch_debouncer #(.WIDTH(5), .CNT_MAX(8)) dut_b (
        .clk(clk), .rst(rst_b), .sw_raw(raw_b),
        .sw_out(out_b), .changed(chg_b), .change_mask(mask_b)
    );
    switch_debouncer #(.WIDTH(5), .CNT_MAX(1)) dut_c (
        .clk(clk), .rst(rst_c), .sw_raw(raw_c),
        .sw_out(out_c), .changed(chg_c), .change_mask(mask_c)
    );

    // Reference model: raw input seen two edges late; a bit flips once it has
    // disagreed with the output for cnt_max consecutive cycles.
    logic [4:0] m_hist1 [3];
    logic [4:0] m_hist2 [3];
    logic [4:0] m_out   [3];
    logic [4:0] m_mask  [3];
    int         m_streak[3][5];

    function automatic int cnt_max_of(int k);
        case (k)
            0:       return 4;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic void model_step(int k, logic r, logic [4:0] raw);
        logic [4:0] flips;
        flips = '0;
        if (r) begin
            m_hist1[k] = '0;
            m_hist2[k] = '0;
            m_out[k]   = '0;
            m_mask[k]  = '0;
            for (int b = 0; b < 5; b++) m_streak[k][b] = 0;
            return;
        end
        for (int b = 0; b < 5; b++) begin
            if (m_hist2[k][b] != m_out[k][b]) begin
                m_streak[k][b] = m_streak[k][b] + 1;
                if (m_streak[k][b] >= cnt_max_of(k)) begin
                    flips[b]       = 1'b1;
                    m_streak[k][b] = 0;
                end
            end else begin
                m_streak[k][b] = 0;
            end
        end
        m_out[k]   = m_out[k] ^ flips;
        m_mask[k]  = flips;
        m_hist2[k] = m_hist1[k];
        m_hist1[k] = raw;
    endfunction

    function automatic logic [10:0] model_of(int k);
        return {m_out[k], (m_mask[k] != 5'b0), m_mask[k]};
    endfunction

    function automatic logic [10:0] dut_of(int k);
        case (k)
            0:       return {out_a, chg_a, mask_a};
            1:       return {out_b, chg_b, mask_b};
            default: return {out_c, chg_c, mask_c};
        endcase
    endfunction

    // Advance one clock: inputs present at the edge feed both DUT and model.
    task automatic tick();
        logic       ra, rb, rc;
        logic [4:0] wa, wb, wc;
        ra = rst_a; rb = rst_b; rc = rst_c;
        wa = raw_a; wb = raw_b; wc = raw_c;
        @(posedge clk);
        model_step(0, ra, wa);
        model_step(1, rb, wb);
        model_step(2, rc, wc);
        #1;
    endtask

    task automatic do_reset(int k);
        case (k)
            0:       begin rst_a = 1'b1; raw_a = '0; end
            1:       begin rst_b = 1'b1; raw_b = '0; end
            default: begin rst_c = 1'b1; raw_c = '0; end
        endcase
        repeat (2) tick();
        case (k)
            0:       rst_a = 1'b0;
            1:       rst_b = 1'b0;
            default: rst_c = 1'b0;
        endcase
    endtask

    task automatic test_reset();
        logic [10:0] g;
        rst_a = 1'b1;
        raw_a = '0;
        for (int i = 0; i < 23; i++) begin
            if (i == 3) rst_a = 1'b0;
            tick();
            g = dut_of(0);
            checks++;
            if (g !== 11'd0) begin
                errors++;
                $display("FAIL reset_release cyc %0d: got %b want %b", i, g, 11'd0);
            end
        end
    endtask

    task automatic test_single();
        logic [10:0] g, e;
        do_reset(0);
        raw_a = 5'b00001;
        for (int i = 1; i <= 9; i++) begin
            tick();
            g = dut_of(0);
            e = {(i >= 6) ? 5'b00001 : 5'b00000, (i == 6), (i == 6) ? 5'b00001 : 5'b00000};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL single_bit cyc %0d: got %b want %b", i, g, e);
            end
            checks++;
            if (g !== model_of(0)) begin
                errors++;
                $display("FAIL single_bit_model cyc %0d: got %b want %b", i, g, model_of(0));
            end
        end
    endtask

    task automatic test_bounce();
        logic [10:0] g, e;
        int pulses;
        pulses = 0;
        do_reset(0);
        for (int i = 1; i <= 14; i++) begin
            raw_a = (i > 5 || (i % 2) == 1) ? 5'b00100 : 5'b00000;
            tick();
            g = dut_of(0);
            if (chg_a) pulses++;
            e = {(i >= 10) ? 5'b00100 : 5'b00000, (i == 10), (i == 10) ? 5'b00100 : 5'b00000};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL bounce cyc %0d: got %b want %b", i, g, e);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        logic [10:0] g, e;
        do_reset(0);
        raw_a = 5'b10011;
        for (int i = 1; i <= 8; i++) begin
            tick();
            g = dut_of(0);
            e = {(i >= 6) ? 5'b10011 : 5'b00000, (i == 6), (i == 6) ? 5'b10011 : 5'b00000};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL simultaneous cyc %0d: got %b want %b", i, g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] g, e;
        logic [4:0]  eo, em;
        do_reset(0);
        for (int i = 1; i <= 9; i++) begin
            raw_a = (i == 1) ? 5'b00001 : 5'b00011;
            tick();
            eo = ((i >= 6) ? 5'b00001 : 5'b0) | ((i >= 7) ? 5'b00010 : 5'b0);
            em = (i == 6) ? 5'b00001 : (i == 7) ? 5'b00010 : 5'b00000;
            e  = {eo, (em != 5'b0), em};
            g  = dut_of(0);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", i, g, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] g, e;
        int pulses;
        pulses = 0;
        do_reset(1);
        raw_b = 5'b11111;
        repeat (5) tick();
        rst_b = 1'b1;
        tick();
        checks++;
        if (dut_of(1) !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_in_reset: got %b want %b", dut_of(1), 11'd0);
        end
        rst_b = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            g = dut_of(1);
            if (chg_b) pulses++;
            e = {(i >= 10) ? 5'b11111 : 5'b00000, (i == 10), (i == 10) ? 5'b11111 : 5'b00000};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: got %b want %b", i, g, e);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL reset_mid_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_falling();
        logic [10:0] g, e;
        do_reset(2);
        raw_c = 5'b01000;
        repeat (3) tick();
        checks++;
        if (dut_of(2) !== {5'b01000, 1'b1, 5'b01000}) begin
            errors++;
            $display("FAIL min_param_rise: got %b want %b", dut_of(2), {5'b01000, 1'b1, 5'b01000});
        end
        tick();
        raw_c = 5'b00000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            g = dut_of(2);
            e = {(i >= 3) ? 5'b00000 : 5'b01000, (i == 3), (i == 3) ? 5'b01000 : 5'b00000};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL falling cyc %0d: got %b want %b", i, g, e);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] flip;
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < 3; k++) begin
                flip = '0;
                for (int b = 0; b < 5; b++) flip[b] = ($urandom_range(0, 9) == 0);
                case (k)
                    0:       raw_a = raw_a ^ flip;
                    1:       raw_b = raw_b ^ flip;
                    default: raw_c = raw_c ^ flip;
                endcase
            end
            rst_a = ($urandom_range(0, 149) == 0);
            rst_b = ($urandom_range(0, 199) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_of(k) !== model_of(k)) begin
                    errors++;
                    $display("FAIL random inst %0d cyc %0d: got %b want %b", k, i, dut_of(k), model_of(k));
                end
            end
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    initial begin
        rst_c = 1'b0;
        test_reset();
        test_single();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_falling();
        do_reset(0);
        do_reset(1);
        do_reset(2);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
